// File: rtl/key_encode83_if.sv
// Event-side bundle for key_encode83: raw keys and consumer controls in,
// held event and status out.
interface key_encode83_if;
    logic [7:0] key;
    logic       ev_ready;
    logic       ovr_clr;
    logic       ev_valid;
    logic [2:0] ev_code;
    logic       ev_multi;
    logic       overrun;
    logic       busy;

    modport master (
        output key,
        output ev_ready,
        output ovr_clr,
        input  ev_valid,
        input  ev_code,
        input  ev_multi,
        input  overrun,
        input  busy
    );

    modport slave (
        input  key,
        input  ev_ready,
        input  ovr_clr,
        output ev_valid,
        output ev_code,
        output ev_multi,
        output overrun,
        output busy
    );
endinterface

// File: rtl/key_encode83.sv
// Debounced 8-to-3 priority key encoder with a one-deep event register.
// key[7] is highest priority and encodes to 0; key[0] encodes to 7.
//
// state    | meaning
// ---------|-----------------------------------------------------------
// IDLE     | no key active, waiting for a press
// DEBOUNCE | key set captured in snap, counting identical samples
// PRESSED  | press accepted and emitted, waiting for all keys released
// RELEASE  | all keys released, counting identical idle samples
module key_encode83 #(
    parameter int unsigned DEB = 3
) (
    input logic           clk1h,
    input logic           rst,
    key_encode83_if.slave kif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(DEB - 1);

    function automatic logic [2:0] enc_code(input logic [7:0] v);
        logic [2:0] code;
        code = 3'd0;
        // Ascending scan so the highest set bit is the last one written.
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                code = 3'(7 - i);
            end
        end
        return code;
    endfunction

    function automatic logic is_multi(input logic [7:0] v);
        return |(v & (v - 8'd1));
    endfunction

    logic [7:0] key_m_q, key_s_q;
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] snap_q, snap_d;
    logic       ev_valid_q, ev_valid_d;
    logic [2:0] ev_code_q, ev_code_d;
    logic       ev_multi_q, ev_multi_d;
    logic       overrun_q, overrun_d;
    logic       busy_q, busy_d;

    logic [7:0] act;
    logic       emit;
    logic       drop;

    assign act = ~key_s_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        emit    = 1'b0;

        case (state_q)
            IDLE: begin
                if (act != 8'h00) begin
                    state_d = DEBOUNCE;
                    snap_d  = act;
                    cnt_d   = 4'd1;
                end
            end
            DEBOUNCE: begin
                if (act == snap_q) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = PRESSED;
                        cnt_d   = 4'd0;
                        emit    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else if (act != 8'h00) begin
                    snap_d = act;
                    cnt_d  = 4'd1;
                end else begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            end
            PRESSED: begin
                if (act == 8'h00) begin
                    state_d = RELEASE;
                    cnt_d   = 4'd1;
                end
            end
            RELEASE: begin
                if (act == 8'h00) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else begin
                    state_d = PRESSED;
                    cnt_d   = 4'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_comb begin
        ev_valid_d = ev_valid_q;
        ev_code_d  = ev_code_q;
        ev_multi_d = ev_multi_q;
        drop       = 1'b0;

        if (emit) begin
            if (!ev_valid_q || kif.ev_ready) begin
                ev_valid_d = 1'b1;
                ev_code_d  = enc_code(snap_q);
                ev_multi_d = is_multi(snap_q);
            end else begin
                drop = 1'b1;
            end
        end else if (ev_valid_q && kif.ev_ready) begin
            ev_valid_d = 1'b0;
        end

        // A drop on the same edge as a clear must leave the flag set.
        overrun_d = (overrun_q & ~kif.ovr_clr) | drop;
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk1h or negedge rst) begin
        if (!rst) begin
            key_m_q    <= 8'hFF;
            key_s_q    <= 8'hFF;
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            snap_q     <= 8'h00;
            ev_valid_q <= 1'b0;
            ev_code_q  <= 3'd0;
            ev_multi_q <= 1'b0;
            overrun_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            key_m_q    <= kif.key;
            key_s_q    <= key_m_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            snap_q     <= snap_d;
            ev_valid_q <= ev_valid_d;
            ev_code_q  <= ev_code_d;
            ev_multi_q <= ev_multi_d;
            overrun_q  <= overrun_d;
            busy_q     <= busy_d;
        end
    end

    assign kif.ev_valid = ev_valid_q;
    assign kif.ev_code  = ev_code_q;
    assign kif.ev_multi = ev_multi_q;
    assign kif.overrun  = overrun_q;
    assign kif.busy     = busy_q;

endmodule

// File: doc/key_encode83.md
KEY_ENCODE83 -- requirements
Module: key_encode83

Interface
REQ-001 Parameter DEB, default 3, meaning consecutive identical samples required to accept a press or release; legal range 2..15.
REQ-002 clk1h  input  1  event/sample clock from the divide block; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 key  input  8  raw active-low keys, asynchronous; key[7] pairs with code 0 and key[0] with code 7, the inverse of decode38.
REQ-005 ev_ready  input  1  consumer accepts the current event.
REQ-006 ovr_clr  input  1  synchronous clear of the overrun flag.
REQ-007 ev_valid  output  1  event register holds an unconsumed press event.
REQ-008 ev_code  output  3  encoded key of the held event.
REQ-009 ev_multi  output  1  more than one key was active in the accepted snapshot.
REQ-010 overrun  output  1  sticky flag: a press event was dropped.
REQ-011 busy  output  1  FSM not in IDLE.

Function
REQ-012 key SHALL pass a 2-flop synchronizer (key_s); act = ~key_s; FSM uses act only.
REQ-013 FSM states SHALL be IDLE, DEBOUNCE, PRESSED and RELEASE; a 4-bit counter cnt and an 8-bit snapshot snap support the FSM.
REQ-014 IDLE: act!=0 -> DEBOUNCE, snap<=act, cnt<=1; act==0 -> stay.
REQ-015 DEBOUNCE: act==snap and cnt==DEB-1 -> PRESSED, emit event, cnt<=0; act==snap otherwise -> cnt+1.
REQ-016 DEBOUNCE: act!=snap and act!=0 -> snap<=act, cnt<=1, stay; act==0 -> IDLE, cnt<=0, no event.
REQ-017 PRESSED: act==0 -> RELEASE, cnt<=1; any nonzero act, including a changed key set, -> stay with no new event.
REQ-018 RELEASE: act==0 and cnt==DEB-1 -> IDLE, cnt<=0; act==0 otherwise -> cnt+1; act!=0 -> PRESSED, cnt<=0, no event.
REQ-019 Encoding: ev_code = 7 - (index of highest set bit of snap); priority runs key[7] highest to key[0] lowest.
REQ-020 ev_multi SHALL be 1 when popcount(snap) >= 2.
REQ-021 Latency: a key level first sampled by the synchronizer at edge k, held stable, SHALL make ev_valid high after edge k+DEB+1.
REQ-022 Emit when ev_valid=0: ev_valid<=1 and ev_code/ev_multi are loaded.
REQ-023 Emit when ev_valid=1 and ev_ready=1: the new event loads, ev_valid stays 1, overrun unchanged.
REQ-024 Emit when ev_valid=1 and ev_ready=0: the event is dropped, held event is unchanged, overrun<=1.
REQ-025 Non-emit edge with ev_valid=1 and ev_ready=1: ev_valid<=0; ev_code/ev_multi hold their last value.
REQ-026 ev_code/ev_multi SHALL be stable while ev_valid=1 and ev_ready=0.
REQ-027 ovr_clr=1 clears overrun; simultaneous overrun set and ovr_clr SHALL leave overrun=1 (set wins).
REQ-028 busy SHALL be registered-state decode: 1 whenever state != IDLE.

Reset
REQ-029 rst low SHALL immediately force: key_s=8'hFF, state IDLE, cnt=0, snap=0, ev_valid=0, ev_code=0, ev_multi=0, overrun=0, busy=0.
REQ-030 Reset mid-debounce or with an event pending SHALL discard all progress; a key held through reset release SHALL be treated as a new press (full DEB debounce, one event).
REQ-031 Release of rst need not be synchronized here; the upstream rst is shared with divide and the led counter.

Verification
REQ-032 DEB=3, ev_ready=1, key=8'h7F held from edge 0 -> ev_valid high after edge 4, ev_code=0, ev_multi=0, one-cycle pulse, busy until release debounced.
REQ-033 key=8'hFE then 8'hF6 (bits 0 and 3) held -> single event ev_code=4, ev_multi=1.
REQ-034 Bounce: key=8'hBF for 2 samples, 8'hFF for 1 sample, then 8'hBF stable -> exactly one event, code=1, no event for the glitch.
REQ-035 ev_ready=0; press key[2], release and debounce, press key[5] -> first event held (code=5), overrun=1 after second press; ovr_clr=1 -> overrun=0.
REQ-036 Held key with 1-sample release glitch in RELEASE -> returns to PRESSED, no second event; assert rst mid-DEBOUNCE -> all outputs reset immediately.
